// File: rtl/hazard_pkg.sv
// ============================================================================
// Module  : hazard_pkg
// Brief   : Shared types and constants for the pipeline hazard controller:
//           FSM state encoding, register-index width, stall-counter width and
//           the register-match helper used by the hazard detectors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package hazard_pkg;

    // Architectural register index width (32 GPRs)
    localparam int REG_W = 5;

    // Stall performance counter width
    localparam int CNT_W = 32;

    // Memory-wait FSM
    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_MWAIT = 1'b1
    } state_t;

    // A source register collides with the EX destination only when it is a
    // real register; r0 is hard-wired to zero and never creates a dependency.
    function automatic logic reg_match(
        input logic [REG_W-1:0] src,
        input logic [REG_W-1:0] wreg
    );
        return (src != '0) && (src == wreg);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Brief   : Up-counter with synchronous clear that sticks at all-ones instead
//           of wrapping.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter
    import hazard_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic             w_sat;

    assign w_sat   = &r_count;
    assign o_count = r_count;

    // Count enabled cycles, clearing on reset and holding once saturated
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_en && !w_sat) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// ============================================================================
// Module  : hazard_ctrl
// Brief   : Pipeline hazard controller. Arbitrates data-memory wait states,
//           taken branches, load-use / JR data hazards and unconditional
//           jumps into PC / IF-ID enables, flush and hold controls.
//           Priority: mem stall > branch taken > load-use/JR > J/JR.
//           Optional build macro HAZARD_PERF_CNT_EN adds a saturating count
//           of cycles in which the PC was held; otherwise stall_cycles is 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_j,
    input  logic             id_jr,
    input  logic             ex_memread,
    input  logic             ex_regwrite,
    input  logic [REG_W-1:0] ex_wreg,
    input  logic             ex_branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cycles
);

    state_t r_state;
    state_t w_state_next;

    logic w_rs_match;
    logic w_rt_match;
    logic w_load_use;
    logic w_jr_haz;
    logic w_data_haz;
    logic w_jump;
    logic w_mem_stall;

    // Hazard detection against the EX-stage destination
    assign w_rs_match  = reg_match(id_rs, ex_wreg);
    assign w_rt_match  = reg_match(id_rt, ex_wreg);
    assign w_load_use  = ex_memread &&
                         ((id_uses_rs && w_rs_match) || (id_uses_rt && w_rt_match));
    // JR reads its target in ID, so any in-flight producer of rs must drain
    assign w_jr_haz    = id_jr && ex_regwrite && w_rs_match;
    assign w_data_haz  = w_load_use || w_jr_haz;
    assign w_jump      = id_j || (id_jr && !w_jr_haz);

    // A zero-wait access (req and ready together in RUN) does not stall
    assign w_mem_stall = ((r_state == ST_RUN)   && mem_req && !mem_ready) ||
                         ((r_state == ST_MWAIT) && !mem_ready);

    // FSM state register; reset abandons any pending memory wait
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and prioritised pipeline controls
    always_comb begin
        w_state_next = r_state;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_flush   = 1'b0;
        pipe_hold    = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (mem_req && !mem_ready) begin
                    w_state_next = ST_MWAIT;
                end
            end
            ST_MWAIT: begin
                if (mem_ready) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase

        if (reset) begin
            // Keep fetch frozen and both front registers squashed to NOPs
            w_state_next = ST_RUN;
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
        end else if (w_mem_stall) begin
            // Freeze the whole pipe; nothing may be squashed while frozen
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            pipe_hold    = 1'b1;
        end else if (ex_branch_taken) begin
            // Redirect fetch and kill the two younger wrong-path instructions
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
        end else if (w_data_haz) begin
            // Hold PC and IF/ID, insert one bubble into EX
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_flush   = 1'b1;
        end else if (w_jump) begin
            // Jump target resolves in ID; drop the sequential fetch
            ifid_flush   = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic w_cnt_en;

    assign w_cnt_en = !reset && !pc_write;

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk     (clk),
        .rst     (reset),
        .i_en    (w_cnt_en),
        .o_count (stall_cycles)
    );
`else
    assign stall_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-002 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-003 SHALL have port id_rs, input, 5: rs field of instruction in ID.
REQ-004 SHALL have port id_rt, input, 5: rt field of instruction in ID.
REQ-005 SHALL have port id_uses_rs and id_uses_rt, input, 1 each: ID instruction reads rs / rt.
REQ-006 SHALL have port id_j and id_jr, input, 1 each: J / JR decoded in ID.
REQ-007 SHALL have port ex_memread, ex_regwrite, input, 1 each: EX-stage instruction is a load / writes a register.
REQ-008 SHALL have port ex_wreg, input, 5: destination register of the EX-stage instruction.
REQ-009 SHALL have port ex_branch_taken, input, 1: branch resolved taken in EX.
REQ-010 SHALL have port mem_req and mem_ready, input, 1 each: MEM-stage access request; data memory completion.
REQ-011 SHALL have port pc_write, ifid_write, input-side enables, output, 1 each: PC and IF/ID load enables.
REQ-012 SHALL have port ifid_flush, idex_flush, output, 1 each: squash the register contents to a NOP.
REQ-013 SHALL have port pipe_hold, output, 1: freeze ID/EX, EX/MEM and MEM/WB.
REQ-014 SHALL have port stall_cycles, output, 32: count of cycles spent stalled.

Function
REQ-015 SHALL implement FSM RUN/MWAIT. RUN->MWAIT when mem_req && !mem_ready. MWAIT->RUN on mem_ready.
REQ-016 SHALL treat mem_req && mem_ready in RUN as a zero-wait access. No stall results.
REQ-017 SHALL drive pipe_hold=1, pc_write=0, ifid_write=0 and no flushes while mem stall = (RUN && mem_req && !mem_ready) || (MWAIT && !mem_ready).
REQ-018 SHALL release all holds in the cycle mem_ready is high in MWAIT.
REQ-019 SHALL define hazard register match as reg!=0 && reg==ex_wreg.
REQ-020 SHALL define load-use as ex_memread && ((id_uses_rs && match(id_rs)) || (id_uses_rt && match(id_rt))).
REQ-021 SHALL define JR hazard as id_jr && ex_regwrite && match(id_rs).
REQ-022 SHALL respond to load-use or JR hazard with pc_write=0, ifid_write=0, idex_flush=1 for exactly one cycle.
REQ-023 SHALL respond to ex_branch_taken with pc_write=1, ifid_flush=1, idex_flush=1.
REQ-024 SHALL respond to id_j, or id_jr with no JR hazard, with ifid_flush=1, pc_write=1.
REQ-025 SHALL apply priority mem stall > branch taken > load-use/JR hazard > J/JR. The lower-priority request is fully suppressed.
REQ-026 SHALL otherwise drive pc_write=1, ifid_write=1 and all flushes/holds 0.
REQ-027 SHALL keep all outputs except stall_cycles combinational from state and inputs.

Reset
REQ-028 SHALL, while reset=1, force state=RUN, pc_write=0, ifid_write=0, ifid_flush=1, idex_flush=1, pipe_hold=0, stall_cycles=0.
REQ-029 SHALL abandon a pending MWAIT on reset mid-wait. Operation returns to RUN on the first cycle after reset deasserts.

Configuration
REQ-030 SHALL compile the stall counter in only with macro HAZARD_PERF_CNT_EN.
REQ-031 SHALL, with HAZARD_PERF_CNT_EN, increment stall_cycles each cycle pc_write=0 outside reset. The counter saturates at 0xFFFFFFFF.
REQ-032 SHALL, without HAZARD_PERF_CNT_EN, tie stall_cycles to 0 and contain no counter flops.

Structure
REQ-033 SHALL place the FSM state type, register-index width (5) and counter width (32) in shared package hazard_pkg.
REQ-034 SHALL implement the saturating counter as sub-module sat_counter. It is instantiated only under HAZARD_PERF_CNT_EN.

Verification
REQ-035 SHALL cover load-use: ex_memread=1, ex_wreg=8, id_rs=8, id_uses_rs=1 -> one cycle pc_write=0, ifid_write=0, idex_flush=1. Same with ex_wreg=0 -> no stall.
REQ-036 SHALL cover memory wait: mem_req=1, mem_ready low 3 cycles then high -> pipe_hold=1 for 3 cycles, released on the ready cycle. With HAZARD_PERF_CNT_EN, stall_cycles=3.
REQ-037 SHALL cover priority: ex_branch_taken=1 together with a load-use hazard -> ifid_flush=1, idex_flush=1, pc_write=1. Adding mem stall -> pipe_hold=1 and no flushes.
REQ-038 SHALL cover JR: id_jr=1, ex_regwrite=1, ex_wreg=id_rs=31 -> one-cycle stall, then ifid_flush=1 next cycle.
REQ-039 SHALL cover reset mid-MWAIT: reset pulsed in MWAIT -> state RUN, stall_cycles=0, mem_ready later ignored.
REQ-040 SHALL cover saturation: stall_cycles preset via force to 0xFFFFFFFE, then 3 stall cycles -> stall_cycles=0xFFFFFFFF.
